// File: rtl/gray_updn_cntr_if.sv
// -----------------------------------------------------------------------------
// gray_updn_cntr_if
//
// Groups the control and status signals of the up/down Gray counter.
// Clock and reset are not part of the bundle; they remain plain ports on the
// counter.
//
//   cen        : count enable, active high                 (master -> slave)
//   up_dn      : direction, 1 = up, 0 = down                 (master -> slave)
//   load       : synchronous load, active high               (master -> slave)
//   data       : Gray-coded value to load                    (master -> slave)
//   count      : registered Gray-coded count                 (slave -> master)
//   bin_out    : registered binary equivalent of count       (slave -> master)
//   tercnt     : terminal-count flag for current direction   (slave -> master)
//   decode_out : one-hot decode of bin_out                   (slave -> master)
//
// The counter instance is the slave; whoever steers it is the master.
// -----------------------------------------------------------------------------
interface gray_updn_cntr_if #(
   parameter int width = 8
);

   logic                    cen;
   logic                    up_dn;
   logic                    load;
   logic [width-1:0]        data;
   logic [width-1:0]        count;
   logic [width-1:0]        bin_out;
   logic                    tercnt;
   logic [(2**width)-1:0]   decode_out;

   modport master (
      output cen,
      output up_dn,
      output load,
      output data,
      input  count,
      input  bin_out,
      input  tercnt,
      input  decode_out
   );

   modport slave (
      input  cen,
      input  up_dn,
      input  load,
      input  data,
      output count,
      output bin_out,
      output tercnt,
      output decode_out
   );

endinterface : gray_updn_cntr_if

// File: rtl/gray_updn_cntr.sv
// -----------------------------------------------------------------------------
// gray_updn_cntr
//
// Parameterised up/down Gray-code counter with synchronous load, count enable,
// terminal-count flag, registered binary shadow and an optional one-hot decode
// of the binary position. Intended for bidirectional or preloadable Gray
// pointers (async FIFO pointers, position sequencers, encoder emulation).
//
// Parameters:
//   width     : counter width in bits, 1..16
//   DECODE_EN : 1 = decode_out active, 0 = decode_out held at all zeros
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : gray_updn_cntr_if.slave
//             in : cen, up_dn, load, data
//             out: count, bin_out, tercnt, decode_out
//
// Per-edge priority: load, then enabled count (up or down), then hold.
// The single state variable is the binary position b_q. The Gray output is
// kept in its own register, loaded with the Gray form of the next binary
// value, so count is glitch-free and changes in exactly one bit per step.
// tercnt and decode_out are combinational from b_q and therefore move in the
// same cycle as count.
// -----------------------------------------------------------------------------
module gray_updn_cntr #(
   parameter int width     = 8,
   parameter int DECODE_EN = 1
) (
   input  logic           clk,
   input  logic           reset,
   gray_updn_cntr_if.slave bus
);

   localparam logic [width-1:0] ONE     = width'(1);
   localparam logic [width-1:0] ALL_ONE = '1;

   // ---------------------------------------------------------------------------
   // Code conversions
   // ---------------------------------------------------------------------------

   // Binary to Gray: adjacent binary values differ in exactly one Gray bit,
   // including the wrap between all-ones and zero.
   function automatic logic [width-1:0] bin2gray(input logic [width-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it,
   // built MSB-first as a running XOR.
   function automatic logic [width-1:0] gray2bin(input logic [width-1:0] g);
      logic [width-1:0] r;
      r[width-1] = g[width-1];
      for (int i = width - 2; i >= 0; i--) begin
         r[i] = r[i+1] ^ g[i];
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [width-1:0]      b_q;       // binary position
   logic [width-1:0]      b_d;
   logic [width-1:0]      count_q;   // registered Gray form of b_q
   logic [(2**width)-1:0] decode_d;
   logic                  tercnt_d;

   // Next binary position. Load overrides the enable; wrap in both directions
   // falls out of modulo-2**width arithmetic, so there is no saturation.
   // NOTE: b_d gets its hold value first, so every path assigns it and no latch
   // is inferred.
   always_comb begin
      b_d = b_q;
      if (bus.load) begin
         b_d = gray2bin(bus.data);
      end else if (bus.cen) begin
         if (bus.up_dn) begin
            b_d = b_q + ONE;
         end else begin
            b_d = b_q - ONE;
         end
      end
   end

   // On load, bin2gray(gray2bin(data)) equals data, so count takes the loaded
   // Gray value directly without a separate path.
   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, and both are cleared by the async reset so
   // no output depends on power-up contents.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         b_q     <= '0;
         count_q <= '0;
      end else begin
         b_q     <= b_d;
         count_q <= bin2gray(b_d);
      end
   end

   // ---------------------------------------------------------------------------
   // Status outputs
   // ---------------------------------------------------------------------------

   // Terminal count refers to the boundary the counter would wrap across next
   // in the currently selected direction; independent of cen and load.
   always_comb begin
      tercnt_d = 1'b0;
      if (bus.up_dn) begin
         tercnt_d = (b_q == ALL_ONE);
      end else begin
         tercnt_d = (b_q == '0);
      end
   end

   // One-hot of the binary position, or all zeros when the decoder is disabled.
   always_comb begin
      decode_d = '0;
      if (DECODE_EN != 0) begin
         decode_d[b_q] = 1'b1;
      end
   end

   assign bus.count      = count_q;
   assign bus.bin_out    = b_q;
   assign bus.tercnt     = tercnt_d;
   assign bus.decode_out = decode_d;

endmodule : gray_updn_cntr

// File: tb/tb_gray_updn_cntr.sv
// -----------------------------------------------------------------------------
// tb_gray_updn_cntr
//
// Directed bench for gray_updn_cntr. Three instances share clk and reset:
//   u_dut4 : width=4, DECODE_EN=1  (main directed sequences)
//   u_dut1 : width=1, DECODE_EN=0  (minimum width, decoder disabled)
//   u_dut8 : width=8, DECODE_EN=1  (random traffic against a small model)
// Inputs change 1 time unit after a rising edge; outputs are read at the same
// point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_gray_updn_cntr;

   logic clk;
   logic reset;

   int n_cmp = 0;
   int n_err = 0;

   gray_updn_cntr_if #(.width(4)) if4 ();
   gray_updn_cntr_if #(.width(1)) if1 ();
   gray_updn_cntr_if #(.width(8)) if8 ();

   gray_updn_cntr #(.width(4), .DECODE_EN(1)) u_dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (if4)
   );

   gray_updn_cntr #(.width(1), .DECODE_EN(0)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );

   gray_updn_cntr #(.width(8), .DECODE_EN(1)) u_dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (if8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so the run always ends.
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (no checking inside)
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      if4.cen = 1'b0; if4.up_dn = 1'b1; if4.load = 1'b0; if4.data = '0;
      if1.cen = 1'b0; if1.up_dn = 1'b1; if1.load = 1'b0; if1.data = '0;
      if8.cen = 1'b0; if8.up_dn = 1'b1; if8.load = 1'b0; if8.data = '0;
   endtask

   // Reset asserted for one edge, released mid-cycle.
   task automatic apply_reset();
      reset = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Reset state and full up sequence with wrap
   // ---------------------------------------------------------------------------
   task automatic test_up_wrap();
      logic [3:0] gseq [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8,
                                4'h0};
      logic [3:0]  prev;
      logic [3:0]  exp_bin;
      logic [15:0] exp_dec;
      idle_all();
      apply_reset();

      n_cmp++;
      if (if4.count !== 4'h0) begin
         n_err++; $display("FAIL reset_count: got %h want 0", if4.count);
      end
      n_cmp++;
      if (if4.bin_out !== 4'h0) begin
         n_err++; $display("FAIL reset_bin: got %h want 0", if4.bin_out);
      end
      n_cmp++;
      if (if4.decode_out !== 16'h0001) begin
         n_err++; $display("FAIL reset_decode: got %h want 0001", if4.decode_out);
      end
      n_cmp++;
      if (if4.tercnt !== 1'b0) begin
         n_err++; $display("FAIL reset_tercnt_up: got %b want 0", if4.tercnt);
      end
      if4.up_dn = 1'b0;
      #1;
      n_cmp++;
      if (if4.tercnt !== 1'b1) begin
         n_err++; $display("FAIL reset_tercnt_dn: got %b want 1", if4.tercnt);
      end

      if4.up_dn = 1'b1;
      if4.cen   = 1'b1;
      prev      = 4'h0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         exp_bin = 4'(i % 16);
         exp_dec = 16'h1 << exp_bin;
         n_cmp++;
         if (if4.count !== gseq[i]) begin
            n_err++; $display("FAIL up_count[%0d]: got %h want %h", i, if4.count, gseq[i]);
         end
         n_cmp++;
         if (if4.bin_out !== exp_bin) begin
            n_err++; $display("FAIL up_bin[%0d]: got %0d want %0d", i, if4.bin_out, exp_bin);
         end
         n_cmp++;
         if (if4.tercnt !== (i == 15)) begin
            n_err++; $display("FAIL up_tercnt[%0d]: got %b want %b", i, if4.tercnt, (i == 15));
         end
         n_cmp++;
         if (if4.decode_out !== exp_dec) begin
            n_err++; $display("FAIL up_decode[%0d]: got %h want %h", i, if4.decode_out, exp_dec);
         end
         n_cmp++;
         if ($countones(if4.count ^ prev) != 1) begin
            n_err++; $display("FAIL up_onebit[%0d]: %h -> %h", i, prev, if4.count);
         end
         prev = if4.count;
      end
      if4.cen = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Down count from zero wraps to all ones
   // ---------------------------------------------------------------------------
   task automatic test_down_wrap();
      logic [3:0] gexp [3] = '{4'h8, 4'h9, 4'hB};
      logic [3:0] bexp [3] = '{4'd15, 4'd14, 4'd13};
      idle_all();
      if4.up_dn = 1'b0;
      apply_reset();
      n_cmp++;
      if (if4.tercnt !== 1'b1) begin
         n_err++; $display("FAIL dn_tercnt_at0: got %b want 1", if4.tercnt);
      end
      if4.cen = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (if4.count !== gexp[i]) begin
            n_err++; $display("FAIL dn_count[%0d]: got %h want %h", i, if4.count, gexp[i]);
         end
         n_cmp++;
         if (if4.bin_out !== bexp[i]) begin
            n_err++; $display("FAIL dn_bin[%0d]: got %0d want %0d", i, if4.bin_out, bexp[i]);
         end
         n_cmp++;
         if (if4.tercnt !== 1'b0) begin
            n_err++; $display("FAIL dn_tercnt[%0d]: got %b want 0", i, if4.tercnt);
         end
      end
      if4.cen = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Load has priority over count enable
   // ---------------------------------------------------------------------------
   task automatic test_load_priority();
      idle_all();
      apply_reset();
      if4.cen = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (if4.count !== 4'h3 || if4.bin_out !== 4'd2) begin
         n_err++; $display("FAIL ld_setup: got count %h bin %0d want 3 / 2", if4.count, if4.bin_out);
      end
      if4.load  = 1'b1;
      if4.data  = 4'hC;
      if4.up_dn = 1'b0;
      tick();
      n_cmp++;
      if (if4.count !== 4'hC) begin
         n_err++; $display("FAIL ld_count: got %h want C", if4.count);
      end
      n_cmp++;
      if (if4.bin_out !== 4'd8) begin
         n_err++; $display("FAIL ld_bin: got %0d want 8", if4.bin_out);
      end
      n_cmp++;
      if (if4.decode_out !== 16'h0100) begin
         n_err++; $display("FAIL ld_decode: got %h want 0100", if4.decode_out);
      end
      if4.load  = 1'b0;
      if4.up_dn = 1'b1;
      tick();
      n_cmp++;
      if (if4.count !== 4'hD || if4.bin_out !== 4'd9) begin
         n_err++; $display("FAIL ld_next: got count %h bin %0d want D / 9", if4.count, if4.bin_out);
      end
      if4.cen = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Hold with cen=0, tercnt only at boundary values
   // ---------------------------------------------------------------------------
   task automatic test_hold_tercnt();
      idle_all();
      apply_reset();
      if4.cen = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      if4.cen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (if4.count !== 4'h7 || if4.bin_out !== 4'd5 || if4.decode_out !== 16'h0020) begin
            n_err++;
            $display("FAIL hold[%0d]: got count %h bin %0d dec %h want 7 / 5 / 0020",
                     i, if4.count, if4.bin_out, if4.decode_out);
         end
      end
      if4.up_dn = 1'b0;
      #1;
      n_cmp++;
      if (if4.tercnt !== 1'b0) begin
         n_err++; $display("FAIL hold_tc_dn_mid: got %b want 0", if4.tercnt);
      end
      if4.up_dn = 1'b1;
      #1;
      n_cmp++;
      if (if4.tercnt !== 1'b0) begin
         n_err++; $display("FAIL hold_tc_up_mid: got %b want 0", if4.tercnt);
      end

      // Park at binary 15 (Gray 8) and check both directions.
      if4.load = 1'b1;
      if4.data = 4'h8;
      tick();
      if4.load = 1'b0;
      n_cmp++;
      if (if4.tercnt !== 1'b1) begin
         n_err++; $display("FAIL tc_max_up: got %b want 1", if4.tercnt);
      end
      if4.up_dn = 1'b0;
      #1;
      n_cmp++;
      if (if4.tercnt !== 1'b0) begin
         n_err++; $display("FAIL tc_max_dn: got %b want 0", if4.tercnt);
      end

      // Park at zero and check both directions.
      if4.load = 1'b1;
      if4.data = 4'h0;
      tick();
      if4.load = 1'b0;
      n_cmp++;
      if (if4.tercnt !== 1'b1) begin
         n_err++; $display("FAIL tc_zero_dn: got %b want 1", if4.tercnt);
      end
      if4.up_dn = 1'b1;
      #1;
      n_cmp++;
      if (if4.tercnt !== 1'b0) begin
         n_err++; $display("FAIL tc_zero_up: got %b want 0", if4.tercnt);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Asynchronous reset between edges
   // ---------------------------------------------------------------------------
   task automatic test_async_reset();
      idle_all();
      apply_reset();
      if4.load = 1'b1;
      if4.data = 4'hF;
      tick();
      if4.load = 1'b0;
      n_cmp++;
      if (if4.count !== 4'hF || if4.bin_out !== 4'd10) begin
         n_err++; $display("FAIL ar_setup: got count %h bin %0d want F / 10", if4.count, if4.bin_out);
      end
      if4.cen   = 1'b1;
      if4.up_dn = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (if4.count !== 4'h0 || if4.bin_out !== 4'd0 || if4.decode_out !== 16'h0001) begin
         n_err++;
         $display("FAIL ar_immediate: got count %h bin %0d dec %h want 0 / 0 / 0001",
                  if4.count, if4.bin_out, if4.decode_out);
      end
      #2;
      reset = 1'b1;
      tick();
      n_cmp++;
      if (if4.count !== 4'h1 || if4.bin_out !== 4'd1) begin
         n_err++; $display("FAIL ar_resume: got count %h bin %0d want 1 / 1", if4.count, if4.bin_out);
      end
      if4.cen = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // width=1 with decoder disabled
   // ---------------------------------------------------------------------------
   task automatic test_width1();
      logic [0:0] cexp [3] = '{1'b0, 1'b1, 1'b0};
      idle_all();
      apply_reset();
      if1.cen = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick();
         n_cmp++;
         if (if1.count !== cexp[i] || if1.bin_out !== cexp[i]) begin
            n_err++; $display("FAIL w1_count[%0d]: got %b/%b want %b", i, if1.count, if1.bin_out, cexp[i]);
         end
         n_cmp++;
         if (if1.tercnt !== cexp[i]) begin
            n_err++; $display("FAIL w1_tercnt[%0d]: got %b want %b", i, if1.tercnt, cexp[i]);
         end
         n_cmp++;
         if (if1.decode_out !== 2'b00) begin
            n_err++; $display("FAIL w1_decode[%0d]: got %b want 00", i, if1.decode_out);
         end
      end
      if1.up_dn = 1'b0;
      #1;
      n_cmp++;
      if (if1.tercnt !== 1'b1) begin
         n_err++; $display("FAIL w1_tercnt_dn: got %b want 1", if1.tercnt);
      end
      if1.cen = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // width=8 random traffic against a reference model
   // ---------------------------------------------------------------------------
   function automatic logic [7:0] ref_g2b(input logic [7:0] g);
      logic [7:0] r;
      r = g;
      for (int s = 1; s < 8; s++) r = r ^ (g >> s);
      return r;
   endfunction

   task automatic test_random8();
      logic [7:0]   mb;
      logic [7:0]   eg;
      logic         et;
      logic [255:0] ed;
      logic         l, c, u;
      logic [7:0]   d;
      idle_all();
      apply_reset();
      mb = 8'd0;
      for (int n = 0; n < 10000; n++) begin
         l = ($urandom_range(0, 7) == 0);
         c = ($urandom_range(0, 3) != 0);
         u = $urandom_range(0, 1) != 0;
         d = 8'($urandom_range(0, 255));
         if8.load  = l;
         if8.cen   = c;
         if8.up_dn = u;
         if8.data  = d;
         tick();
         if (l)      mb = ref_g2b(d);
         else if (c) mb = u ? mb + 8'd1 : mb - 8'd1;
         eg = mb ^ (mb >> 1);
         et = u ? (mb == 8'hFF) : (mb == 8'h00);
         ed = 256'b1 << mb;
         n_cmp++;
         if (if8.count !== eg) begin
            n_err++; $display("FAIL rnd_count[%0d]: got %h want %h", n, if8.count, eg);
         end
         n_cmp++;
         if (if8.bin_out !== mb) begin
            n_err++; $display("FAIL rnd_bin[%0d]: got %h want %h", n, if8.bin_out, mb);
         end
         n_cmp++;
         if (if8.tercnt !== et) begin
            n_err++; $display("FAIL rnd_tercnt[%0d]: got %b want %b", n, if8.tercnt, et);
         end
         n_cmp++;
         if (if8.decode_out !== ed) begin
            n_err++; $display("FAIL rnd_decode[%0d]: bin %h, decode bit set=%b, ones=%0d",
                              n, mb, if8.decode_out[mb], $countones(if8.decode_out));
         end
         if (n_err > 40) break;
      end
      idle_all();
   endtask

   // ---------------------------------------------------------------------------
   // Sequence
   // ---------------------------------------------------------------------------
   initial begin
      reset = 1'b0;
      idle_all();
      test_up_wrap();
      test_down_wrap();
      test_load_priority();
      test_hold_tercnt();
      test_async_reset();
      test_width1();
      test_random8();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_gray_updn_cntr
